// File: rtl/fir_out_decimator.sv
// fir_out_decimator
//   Output stage for the symmetric FIR. Each accepted wide sample is
//   arithmetically right-shifted by SHIFT and saturated to DW signed bits.
//   Only every R-th sample is kept (runtime ratio). Kept samples go into a
//   2^AW-deep show-ahead FIFO that drives an AXI-Stream-style master port.
//   The input side never stalls. A sample that arrives while the FIFO is
//   full is dropped, and the sticky ovf_o flag is set.
//
//   Optional build macro: FIR_OUT_ROUND_EN
//     defined   : round half up (adds 2^(SHIFT-1) before the shift)
//     undefined : truncation (floor), so no rounding adder is built
//
//   Ports
//     sys_clk, reset_n : clock, asynchronous active-low reset
//     ce               : clock enable; when low every register holds
//     tdata_s_i        : signed input sample, IW bits
//     tvalid_s_i       : input valid
//     tready_s_o       : input ready; stays 1 after the first enabled edge
//     tdata_m_o        : signed output sample (FIFO head), DW bits
//     tvalid_m_o       : output valid (FIFO not empty)
//     tready_m_i       : output ready
//     dec_ratio        : decimation ratio R (0 and 1 both mean pass-through)
//     fifo_level       : FIFO occupancy, 0..2^AW
//     ovf_o, ovf_clr   : sticky overflow flag and its clear
module fir_out_decimator #(
    parameter int IW    = 22,
    parameter int DW    = 16,
    parameter int SHIFT = 4,
    parameter int AW    = 3
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [IW-1:0] tdata_s_i,
    input  logic          tvalid_s_i,
    output logic          tready_s_o,
    output logic [DW-1:0] tdata_m_o,
    output logic          tvalid_m_o,
    input  logic          tready_m_i,
    input  logic [7:0]    dec_ratio,
    output logic [AW:0]   fifo_level,
    output logic          ovf_o,
    input  logic          ovf_clr
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_P = AW'(1);
    localparam logic signed [IW:0] W_MAX = $signed({{(IW-DW+2){1'b0}}, {(DW-1){1'b1}}});
    localparam logic signed [IW:0] W_MIN = $signed({{(IW-DW+2){1'b1}}, {(DW-1){1'b0}}});

    logic                 r_ready;
    logic [7:0]           r_phase;
    logic                 r_s1_valid;
    logic [DW-1:0]        r_s1_data;
    logic [DW-1:0]        r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [DW-1:0]        r_tdata;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_keep;
    logic [7:0]           w_last;
    logic signed [IW:0]   w_ext;
    logic signed [IW:0]   w_pre;
    logic signed [IW:0]   w_scaled;
    logic [DW-1:0]        w_sat;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [AW-1:0]        w_rd_next;
    logic [AW:0]          w_remain;

    assign w_accept = ce & tvalid_s_i & r_ready;
    assign w_keep   = w_accept & (r_phase == 8'd0);
    // Last phase index for this ratio. The >= compare in the counter lets a
    // lowered ratio wrap at once rather than counting up through 255.
    assign w_last   = (dec_ratio > 8'd1) ? dec_ratio - 8'd1 : 8'd0;

    // One sign bit of headroom, so the rounding add can never wrap.
    assign w_ext = $signed({tdata_s_i[IW-1], tdata_s_i});
`ifdef FIR_OUT_ROUND_EN
    localparam logic [IW:0] RND = (IW+1)'(1) << (SHIFT-1);
    assign w_pre = w_ext + $signed(RND);
`else
    assign w_pre = w_ext;
`endif
    assign w_scaled = w_pre >>> SHIFT;

    always_comb begin
        w_sat = w_scaled[DW-1:0];
        if (w_scaled > W_MAX)
            w_sat = {1'b0, {(DW-1){1'b1}}};
        else if (w_scaled < W_MIN)
            w_sat = {1'b1, {(DW-1){1'b0}}};
    end

    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign w_pop     = ce & (r_count != '0) & tready_m_i;
    assign w_push    = ce & r_s1_valid & ((r_count != FULL) | w_pop);
    assign w_drop    = ce & r_s1_valid & ~w_push;
    assign w_rd_next = w_pop ? r_rd_ptr + ONE_P : r_rd_ptr;
    assign w_remain  = w_pop ? r_count - ONE_C : r_count;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready    <= 1'b0;
            r_phase    <= 8'd0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tdata    <= '0;
            r_ovf      <= 1'b0;
        end else if (ce) begin
            r_ready <= 1'b1;
            if (w_accept)
                r_phase <= (r_phase >= w_last) ? 8'd0 : r_phase + 8'd1;
            r_s1_valid <= w_keep;
            if (w_keep)
                r_s1_data <= w_sat;

            if (w_push)
                r_wr_ptr <= r_wr_ptr + ONE_P;
            r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase

            // Head register. A write into an otherwise empty FIFO bypasses
            // the memory. A pop loads the next entry that is already stored.
            if (w_push && w_remain == '0)
                r_tdata <= r_s1_data;
            else if (w_pop && w_remain != '0)
                r_tdata <= r_mem[w_rd_next];

            // Set wins over clear.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    // The storage array has no reset. The async reset clears the pointers
    // and the count, so stale contents can never be seen.
    always_ff @(posedge sys_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_s1_data;
    end

    assign tready_s_o = r_ready;
    assign tdata_m_o  = r_tdata;
    assign tvalid_m_o = (r_count != '0);
    assign fifo_level = r_count;
    assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Testbench for fir_out_decimator. Directed vectors are used. Expected output
// samples go into a queue when they are driven, and a monitor checks every
// output handshake against that queue.
module tb_fir_out_decimator;

    localparam int IW = 22;
    localparam int DW = 16;
    localparam int AW = 3;

`ifdef FIR_OUT_ROUND_EN
    localparam logic [DW-1:0] E_P24 = 16'h0002;
    localparam logic [DW-1:0] E_M24 = 16'hFFFF;
`else
    localparam logic [DW-1:0] E_P24 = 16'h0001;
    localparam logic [DW-1:0] E_M24 = 16'hFFFE;
`endif

    logic          sys_clk = 1'b0;
    logic          reset_n;
    logic          ce;
    logic [IW-1:0] tdata_s_i;
    logic          tvalid_s_i;
    logic          tready_s_o;
    logic [DW-1:0] tdata_m_o;
    logic          tvalid_m_o;
    logic          tready_m_i;
    logic [7:0]    dec_ratio;
    logic [AW:0]   fifo_level;
    logic          ovf_o;
    logic          ovf_clr;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] q [$];

    fir_out_decimator #(.IW(IW), .DW(DW), .SHIFT(4), .AW(AW)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .tdata_s_i  (tdata_s_i),
        .tvalid_s_i (tvalid_s_i),
        .tready_s_o (tready_s_o),
        .tdata_m_o  (tdata_m_o),
        .tvalid_m_o (tvalid_m_o),
        .tready_m_i (tready_m_i),
        .dec_ratio  (dec_ratio),
        .fifo_level (fifo_level),
        .ovf_o      (ovf_o),
        .ovf_clr    (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: runs on the falling edge and checks each transfer that the
    // next rising edge will complete.
    always @(negedge sys_clk) begin
        if (reset_n && ce && tvalid_m_o && tready_m_i) begin
            if (q.size() == 0) begin
                check("unexpected_out", {16'h0, tdata_m_o}, 32'hDEAD);
            end else begin
                logic [DW-1:0] e;
                e = q.pop_front();
                check("out_data", {16'h0, tdata_m_o}, {16'h0, e});
            end
        end
    end

    task automatic send(input logic [IW-1:0] d, input bit keep, input logic [DW-1:0] e);
        tdata_s_i  = d;
        tvalid_s_i = 1'b1;
        if (keep) q.push_back(e);
        @(posedge sys_clk); #1;
        tvalid_s_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while ((q.size() != 0 || tvalid_m_o) && i < 200) begin
            @(posedge sys_clk); #1;
            i++;
        end
        check({tag, "_queue"}, q.size(), 0);
        check({tag, "_tvalid"}, {31'h0, tvalid_m_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ce = 0; tdata_s_i = '0; tvalid_s_i = 0; tready_m_i = 0;
        dec_ratio = 8'd1; ovf_clr = 0; reset_n = 1;
        #2 reset_n = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_tready_s", {31'h0, tready_s_o}, 0);
        check("rst_tvalid_m", {31'h0, tvalid_m_o}, 0);
        check("rst_tdata_m", {16'h0, tdata_m_o}, 0);
        check("rst_level", {28'h0, fifo_level}, 0);
        check("rst_ovf", {31'h0, ovf_o}, 0);

        reset_n = 1;
        @(posedge sys_clk); #1;
        check("ready_hold_ce0", {31'h0, tready_s_o}, 0);
        ce = 1; tready_m_i = 1;
        @(posedge sys_clk); #1;
        check("ready_up", {31'h0, tready_s_o}, 1);

        // Scaling and latency
        send(22'h000018, 1, E_P24);
        check("lat_edge1", {31'h0, tvalid_m_o}, 0);
        @(posedge sys_clk); #1;
        check("lat_edge2", {31'h0, tvalid_m_o}, 1);
        send(22'h3FFFE8, 1, E_M24);
        send(22'h100000, 1, 16'h7FFF);
        send(22'h200000, 1, 16'h8000);
        send(22'h07FFF0, 1, 16'h7FFF);
        send(22'h1FFFFF, 1, 16'h7FFF);
        wait_drain("scale");

        // Decimation by 4
        dec_ratio = 8'd4;
        for (int n = 0; n < 12; n++)
            send(22'(n << 4), (n % 4) == 0, 16'(n));
        wait_drain("dec4");

        // Lower the ratio from 8 to 2 while phase is 5
        dec_ratio = 8'd8;
        send(22'h000100, 1, 16'h0010);
        for (int n = 1; n < 5; n++)
            send(22'h000100 + 22'(n << 4), 0, 16'h0);
        dec_ratio = 8'd2;
        send(22'h000200, 0, 16'h0);
        send(22'h000210, 1, 16'h0021);
        send(22'h000220, 0, 16'h0);
        wait_drain("r8to2");

        // A ratio of 0 acts as pass-through
        dec_ratio = 8'd0;
        send(22'h000300, 1, 16'h0030);
        send(22'h000310, 1, 16'h0031);
        send(22'h000320, 1, 16'h0032);
        wait_drain("r0");

        // Overflow: the sink is stalled and 10 samples are sent
        dec_ratio = 8'd1;
        tready_m_i = 0;
        for (int n = 0; n < 10; n++)
            send(22'(n << 4), n < 8, 16'(n));
        repeat (2) @(posedge sys_clk);
        #1;
        check("ovf_level", {28'h0, fifo_level}, 8);
        check("ovf_flag", {31'h0, ovf_o}, 1);
        check("ovf_head", {16'h0, tdata_m_o}, 0);
        ce = 0; tready_m_i = 1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("ce0_level", {28'h0, fifo_level}, 8);
        ce = 1;
        wait_drain("ovf");
        check("ovf_sticky", {31'h0, ovf_o}, 1);
        ovf_clr = 1;
        @(posedge sys_clk); #1;
        ovf_clr = 0;
        check("ovf_clr", {31'h0, ovf_o}, 0);

        // Full FIFO with a pop in the same cycle as the write
        tready_m_i = 0;
        for (int n = 0; n < 8; n++)
            send(22'h000100 + 22'(n << 4), 1, 16'h0010 + 16'(n));
        repeat (2) @(posedge sys_clk);
        #1;
        check("full_level", {28'h0, fifo_level}, 8);
        send(22'h000180, 1, 16'h0018);
        tready_m_i = 1;
        @(posedge sys_clk); #1;
        tready_m_i = 0;
        check("pushpop_level", {28'h0, fifo_level}, 8);
        check("pushpop_ovf", {31'h0, ovf_o}, 0);

        // Reset in the middle of the stream
        reset_n = 0;
        #1;
        check("midrst_level", {28'h0, fifo_level}, 0);
        check("midrst_tvalid", {31'h0, tvalid_m_o}, 0);
        q.delete();
        @(posedge sys_clk); #1;
        reset_n = 1;
        @(posedge sys_clk); #1;
        check("midrst_ready", {31'h0, tready_s_o}, 1);
        tready_m_i = 1;
        send(22'h000030, 1, 16'h0003);
        wait_drain("restart");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
